// File: rtl/cache_line_mover_pkg.sv
// Shared types for the cache line mover: FSM state encoding and beat-count helper.
package cache_line_mover_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WB_RD,
        WB_WAIT,
        WB_CMD,
        WB_DATA,
        FILL_CMD,
        FILL_DATA,
        FILL_WR,
        DONE
    } state_t;

    localparam int LINE_SIZE_DEF = 64;
    localparam int MEM_WIDTH_DEF = 64;

    typedef logic [LINE_SIZE_DEF-1:0][7:0] line_t;

    function automatic int calc_beats(input int line_size, input int mem_width);
        return (line_size * 8) / mem_width;
    endfunction

endpackage

// File: rtl/cache_line_mover_line_beat_buffer.sv
// Line-wide holding register: loaded whole from the data array or one memory beat at a time,
// and read out either whole (array write) or one beat at a time (memory write).
module cache_line_mover_line_beat_buffer #(
    parameter int LINE_SIZE = 64,
    parameter int MEM_WIDTH = 64,
    parameter int BEATS     = 8,
    parameter int IDX_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_all,
    input  logic [LINE_SIZE*8-1:0] load_data,
    input  logic                   beat_we,
    input  logic [IDX_W-1:0]       beat_idx,
    input  logic [MEM_WIDTH-1:0]   beat_wdata,
    output logic [MEM_WIDTH-1:0]   beat_rdata,
    output logic [LINE_SIZE*8-1:0] line_data
);

    // Beat i occupies bits [i*MEM_WIDTH +: MEM_WIDTH], matching byte k at [8k +: 8].
    logic [BEATS-1:0][MEM_WIDTH-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_all) begin
            line_q <= load_data;
        end else if (beat_we) begin
            line_q[beat_idx] <= beat_wdata;
        end
    end

    assign beat_rdata = line_q[beat_idx];
    assign line_data  = line_q;

endmodule

// File: rtl/cache_line_mover.sv
// Moves whole cache lines between the data array and the memory port: optional victim
// writeback followed by a line fill, one request at a time.
//
// state     | meaning
// IDLE      | waiting for a controller request
// WB_RD     | one-cycle victim line read strobe to the array
// WB_WAIT   | array read data captured into the line buffer
// WB_CMD    | memory write command offered
// WB_DATA   | victim beats streamed to memory
// FILL_CMD  | memory read command offered
// FILL_DATA | fill beats assembled into the line buffer
// FILL_WR   | one-cycle line write strobe to the array
// DONE      | completion pulse, err valid
module cache_line_mover
    import cache_line_mover_pkg::*;
#(
    parameter int LINE_SIZE     = 64,
    parameter int NUM_SETS      = 64,
    parameter int ASSOCIATIVITY = 4,
    parameter int MEM_WIDTH     = 64,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_writeback,
    input  logic [$clog2(NUM_SETS)-1:0]      req_index,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] req_way,
    input  logic [ADDR_WIDTH-1:0]            req_wb_addr,
    input  logic [ADDR_WIDTH-1:0]            req_fill_addr,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             da_line_read_en,
    output logic                             da_line_write_en,
    output logic [$clog2(NUM_SETS)-1:0]      da_index,
    output logic [$clog2(ASSOCIATIVITY)-1:0] da_way,
    input  logic [LINE_SIZE*8-1:0]           da_line_read_data,
    output logic [LINE_SIZE*8-1:0]           da_line_write_data,
    output logic                             mem_cmd_valid,
    input  logic                             mem_cmd_ready,
    output logic                             mem_cmd_write,
    output logic [ADDR_WIDTH-1:0]            mem_cmd_addr,
    output logic                             mem_wdata_valid,
    input  logic                             mem_wdata_ready,
    output logic [MEM_WIDTH-1:0]             mem_wdata,
    output logic                             mem_wdata_last,
    input  logic                             mem_rdata_valid,
    output logic                             mem_rdata_ready,
    input  logic [MEM_WIDTH-1:0]             mem_rdata,
    input  logic                             mem_rdata_last
);

    localparam int BEATS = calc_beats(LINE_SIZE, MEM_WIDTH);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(ASSOCIATIVITY);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(LINE_SIZE - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic                    err_q;
    logic [SET_W-1:0]        index_q;
    logic [WAY_W-1:0]        way_q;
    logic [ADDR_WIDTH-1:0]   wb_addr_q, fill_addr_q;
    logic                    last_beat;
    logic                    req_fire, wbeat_fire, rbeat_fire;
    logic                    beat_entry;
    logic                    buf_load_all;
    logic [MEM_WIDTH-1:0]    beat_rdata;

    assign last_beat  = (beat_cnt_q == LAST_BEAT);
    assign req_fire   = req_valid & req_ready;
    assign wbeat_fire = mem_wdata_valid & mem_wdata_ready;
    assign rbeat_fire = mem_rdata_valid & mem_rdata_ready;
    assign beat_entry = ((state_d == WB_DATA)   && (state_q != WB_DATA)) ||
                        ((state_d == FILL_DATA) && (state_q != FILL_DATA));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid) state_d = req_writeback ? WB_RD : FILL_CMD;
            WB_RD:     state_d = WB_WAIT;
            WB_WAIT:   state_d = WB_CMD;
            WB_CMD:    if (mem_cmd_ready) state_d = WB_DATA;
            WB_DATA:   if (mem_wdata_ready && last_beat) state_d = FILL_CMD;
            FILL_CMD:  if (mem_cmd_ready) state_d = FILL_DATA;
            FILL_DATA: if (mem_rdata_valid && last_beat) state_d = FILL_WR;
            FILL_WR:   state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready        = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        err              = 1'b0;
        da_line_read_en  = 1'b0;
        da_line_write_en = 1'b0;
        mem_cmd_valid    = 1'b0;
        mem_cmd_write    = 1'b0;
        mem_cmd_addr     = '0;
        mem_wdata_valid  = 1'b0;
        mem_wdata        = '0;
        mem_wdata_last   = 1'b0;
        mem_rdata_ready  = 1'b0;
        buf_load_all     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            WB_RD:   da_line_read_en = 1'b1;
            WB_WAIT: buf_load_all = 1'b1;
            WB_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_write = 1'b1;
                mem_cmd_addr  = wb_addr_q;
            end
            WB_DATA: begin
                mem_wdata_valid = 1'b1;
                mem_wdata       = beat_rdata;
                mem_wdata_last  = last_beat;
            end
            FILL_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = fill_addr_q;
            end
            FILL_DATA: mem_rdata_ready = 1'b1;
            FILL_WR:   da_line_write_en = 1'b1;
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    // Beat count alone ends a fill; rdata_last only feeds the framing error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            index_q     <= '0;
            way_q       <= '0;
            wb_addr_q   <= '0;
            fill_addr_q <= '0;
        end else begin
            if (req_fire) begin
                index_q     <= req_index;
                way_q       <= req_way;
                wb_addr_q   <= req_wb_addr & ADDR_MASK;
                fill_addr_q <= req_fill_addr & ADDR_MASK;
                err_q       <= 1'b0;
            end
            if (beat_entry) begin
                beat_cnt_q <= '0;
            end else if (wbeat_fire || rbeat_fire) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
            if (rbeat_fire && (mem_rdata_last != last_beat)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign da_index = index_q;
    assign da_way   = way_q;

    cache_line_mover_line_beat_buffer #(
        .LINE_SIZE (LINE_SIZE),
        .MEM_WIDTH (MEM_WIDTH),
        .BEATS     (BEATS),
        .IDX_W     (IDX_W)
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .load_all   (buf_load_all),
        .load_data  (da_line_read_data),
        .beat_we    (rbeat_fire),
        .beat_idx   (beat_cnt_q[IDX_W-1:0]),
        .beat_wdata (mem_rdata),
        .beat_rdata (beat_rdata),
        .line_data  (da_line_write_data)
    );

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: drives the request and memory sides, records every
// handshake, and checks data, framing, latency and reset behaviour against hand-derived values.
module tb_cache_line_mover;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_writeback;
    logic [5:0]   req_index;
    logic [1:0]   req_way;
    logic [31:0]  req_wb_addr, req_fill_addr;
    logic         busy, done, err;
    logic         da_line_read_en, da_line_write_en;
    logic [5:0]   da_index;
    logic [1:0]   da_way;
    logic [511:0] da_line_read_data, da_line_write_data;
    logic         mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
    logic [31:0]  mem_cmd_addr;
    logic         mem_wdata_valid, mem_wdata_ready, mem_wdata_last;
    logic [63:0]  mem_wdata;
    logic         mem_rdata_valid, mem_rdata_ready, mem_rdata_last;
    logic [63:0]  mem_rdata;

    int assertions = 0;
    int failures   = 0;
    int we_total   = 0;

    int           n_cmd, n_wbeat, n_rbeat, n_rd_en, n_wr_en, accepts, latency, stab_viol;
    logic         cmd_wr_l   [4];
    logic [31:0]  cmd_addr_l [4];
    logic [63:0]  wbeat_l    [8];
    logic         wlast_l    [8];
    logic [63:0]  rbeats     [8];
    logic [511:0] wr_data;
    logic [5:0]   wr_idx;
    logic [1:0]   wr_way;
    logic         got_done, done_err, aborted;

    always #5 clk = ~clk;

    cache_line_mover dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_writeback      (req_writeback),
        .req_index          (req_index),
        .req_way            (req_way),
        .req_wb_addr        (req_wb_addr),
        .req_fill_addr      (req_fill_addr),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .da_line_read_en    (da_line_read_en),
        .da_line_write_en   (da_line_write_en),
        .da_index           (da_index),
        .da_way             (da_way),
        .da_line_read_data  (da_line_read_data),
        .da_line_write_data (da_line_write_data),
        .mem_cmd_valid      (mem_cmd_valid),
        .mem_cmd_ready      (mem_cmd_ready),
        .mem_cmd_write      (mem_cmd_write),
        .mem_cmd_addr       (mem_cmd_addr),
        .mem_wdata_valid    (mem_wdata_valid),
        .mem_wdata_ready    (mem_wdata_ready),
        .mem_wdata          (mem_wdata),
        .mem_wdata_last     (mem_wdata_last),
        .mem_rdata_valid    (mem_rdata_valid),
        .mem_rdata_ready    (mem_rdata_ready),
        .mem_rdata          (mem_rdata),
        .mem_rdata_last     (mem_rdata_last)
    );

    always @(negedge clk) begin
        if (da_line_write_en) we_total++;
        assertions++;
        assert (!(da_line_read_en && da_line_write_en)) else begin
            failures++;
            $display("FAIL rd_wr_overlap: read_en=%b write_en=%b, required not both high",
                     da_line_read_en, da_line_write_en);
        end
    end

    // Runs one request end to end, playing the memory; records what the DUT did.
    task automatic run_txn(input logic wb, input logic [5:0] idx, input logic [1:0] way,
                           input logic [31:0] wba, input logic [31:0] fa, input int stall_pct,
                           input int last_pos, input int abort_beat, input logic hold_req);
        logic rd_pending, drop_req, r_taken, started;
        logic pv_c, pt_c, pw_c, pv_w, pt_w, pl_w;
        logic [31:0] pa_c;
        logic [63:0] pd_w;
        int lat;
        n_cmd = 0; n_wbeat = 0; n_rbeat = 0; n_rd_en = 0; n_wr_en = 0; accepts = 0;
        latency = 0; stab_viol = 0; got_done = 0; done_err = 0; aborted = 0;
        wr_data = '0; wr_idx = '0; wr_way = '0;
        rd_pending = 0; drop_req = 0; r_taken = 0; started = 0; lat = 0;
        pv_c = 0; pt_c = 0; pw_c = 0; pv_w = 0; pt_w = 0; pl_w = 0; pa_c = '0; pd_w = '0;
        @(negedge clk);
        req_valid = 1'b1; req_writeback = wb; req_index = idx; req_way = way;
        req_wb_addr = wba; req_fill_addr = fa;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (drop_req && !hold_req) req_valid = 1'b0;
            if (r_taken) begin
                n_rbeat++;
                mem_rdata_valid = 1'b0;
                r_taken = 0;
            end
            if (abort_beat >= 0 && n_rbeat == abort_beat) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1;
                break;
            end
            mem_cmd_ready   = ($urandom_range(99) >= stall_pct);
            mem_wdata_ready = ($urandom_range(99) >= stall_pct);
            if (!mem_rdata_valid && rd_pending && n_rbeat < 8 && $urandom_range(99) >= stall_pct) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = rbeats[n_rbeat];
                mem_rdata_last  = (n_rbeat == last_pos);
            end
            if (started) lat++;
            if (req_valid && req_ready) begin
                accepts++;
                drop_req = 1;
                if (!started) begin
                    started = 1;
                    lat = 1;
                end
            end
            if (pv_c && !pt_c && (!mem_cmd_valid || mem_cmd_addr !== pa_c || mem_cmd_write !== pw_c))
                stab_viol++;
            if (pv_w && !pt_w && (!mem_wdata_valid || mem_wdata !== pd_w || mem_wdata_last !== pl_w))
                stab_viol++;
            pv_c = mem_cmd_valid;   pt_c = mem_cmd_ready;   pa_c = mem_cmd_addr; pw_c = mem_cmd_write;
            pv_w = mem_wdata_valid; pt_w = mem_wdata_ready; pd_w = mem_wdata;    pl_w = mem_wdata_last;
            if (mem_cmd_valid && mem_cmd_ready) begin
                if (n_cmd < 4) begin
                    cmd_wr_l[n_cmd]   = mem_cmd_write;
                    cmd_addr_l[n_cmd] = mem_cmd_addr;
                end
                n_cmd++;
                if (!mem_cmd_write) rd_pending = 1;
            end
            if (mem_wdata_valid && mem_wdata_ready) begin
                if (n_wbeat < 8) begin
                    wbeat_l[n_wbeat] = mem_wdata;
                    wlast_l[n_wbeat] = mem_wdata_last;
                end
                n_wbeat++;
            end
            if (mem_rdata_valid && mem_rdata_ready) r_taken = 1;
            if (da_line_read_en) n_rd_en++;
            if (da_line_write_en) begin
                n_wr_en++;
                wr_data = da_line_write_data;
                wr_idx  = da_index;
                wr_way  = da_way;
            end
            if (done) begin
                got_done = 1;
                done_err = err;
                latency  = lat;
                req_valid = 1'b0;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0; mem_cmd_ready = 1'b0; mem_wdata_ready = 1'b0;
        mem_rdata_valid = 1'b0; mem_rdata_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        assertions++;
        if ({req_ready, busy, done, err, da_line_read_en, da_line_write_en, mem_cmd_valid,
             mem_cmd_write, mem_wdata_valid, mem_wdata_last, mem_rdata_ready} !== 11'b100_0000_0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 10000000000",
                     {req_ready, busy, done, err, da_line_read_en, da_line_write_en, mem_cmd_valid,
                      mem_cmd_write, mem_wdata_valid, mem_wdata_last, mem_rdata_ready});
        end
        assertions++;
        if (da_line_write_data !== 512'd0 || mem_wdata !== 64'd0 || mem_cmd_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: write_data/wdata/cmd_addr not all zero (addr=%h)", mem_cmd_addr);
        end
        assertions++;
        if (da_index !== 6'd0 || da_way !== 2'd0) begin
            failures++;
            $display("FAIL reset_index: got index=%0d way=%0d want 0/0", da_index, da_way);
        end
    endtask

    task automatic test_fill_only();
        logic [511:0] exp;
        for (int i = 0; i < 8; i++) rbeats[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        for (int k = 0; k < 64; k++) exp[8*k +: 8] = 8'h11 * 8'(k / 8 + 1);
        run_txn(1'b0, 6'd5, 2'd2, 32'h0, 32'h1234_5678, 0, 7, -1, 1'b0);
        assertions++;
        if (!got_done || latency != 12) begin
            failures++;
            $display("FAIL fill_latency: got done=%0b latency=%0d want 1/12", got_done, latency);
        end
        assertions++;
        if (n_cmd != 1 || cmd_wr_l[0] !== 1'b0 || cmd_addr_l[0] !== 32'h1234_5640) begin
            failures++;
            $display("FAIL fill_cmd: got n=%0d wr=%b addr=%h want 1/0/12345640", n_cmd, cmd_wr_l[0], cmd_addr_l[0]);
        end
        assertions++;
        if (n_wr_en != 1 || wr_idx !== 6'd5 || wr_way !== 2'd2) begin
            failures++;
            $display("FAIL fill_target: got writes=%0d index=%0d way=%0d want 1/5/2", n_wr_en, wr_idx, wr_way);
        end
        assertions++;
        if (wr_data !== exp) begin
            failures++;
            $display("FAIL fill_data: got %h want %h", wr_data[127:0], exp[127:0]);
        end
        assertions++;
        if (n_rd_en != 0 || n_wbeat != 0 || done_err !== 1'b0) begin
            failures++;
            $display("FAIL fill_side: got rd_en=%0d wbeats=%0d err=%b want 0/0/0", n_rd_en, n_wbeat, done_err);
        end
    endtask

    task automatic test_writeback_fill();
        logic [63:0]  exp_beat;
        logic [511:0] exp;
        for (int k = 0; k < 64; k++) da_line_read_data[8*k +: 8] = 8'(k);
        for (int i = 0; i < 8; i++) rbeats[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1);
        for (int i = 0; i < 8; i++) exp[64*i +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i * 3 + 1);
        run_txn(1'b1, 6'd63, 2'd3, 32'hABCD_EF7F, 32'h0000_1004, 0, 7, -1, 1'b0);
        assertions++;
        if (!got_done || n_rd_en != 1) begin
            failures++;
            $display("FAIL wb_done: got done=%0b read_en=%0d want 1/1", got_done, n_rd_en);
        end
        assertions++;
        if (n_cmd != 2 || cmd_wr_l[0] !== 1'b1 || cmd_addr_l[0] !== 32'hABCD_EF40 ||
            cmd_wr_l[1] !== 1'b0 || cmd_addr_l[1] !== 32'h0000_1000) begin
            failures++;
            $display("FAIL wb_cmds: got n=%0d %b/%h %b/%h want 2 1/abcdef40 0/00001000",
                     n_cmd, cmd_wr_l[0], cmd_addr_l[0], cmd_wr_l[1], cmd_addr_l[1]);
        end
        assertions++;
        if (n_wbeat != 8 || wbeat_l[0] !== 64'h0706_0504_0302_0100 || wbeat_l[7] !== 64'h3F3E_3D3C_3B3A_3938) begin
            failures++;
            $display("FAIL wb_beat0_7: got n=%0d b0=%h b7=%h want 8/0706050403020100/3f3e3d3c3b3a3938",
                     n_wbeat, wbeat_l[0], wbeat_l[7]);
        end
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 8; b++) exp_beat[8*b +: 8] = 8'(8 * i + b);
            assertions++;
            if (wbeat_l[i] !== exp_beat || wlast_l[i] !== (i == 7)) begin
                failures++;
                $display("FAIL wb_beat%0d: got %h last=%b want %h last=%b", i, wbeat_l[i], wlast_l[i], exp_beat, i == 7);
            end
        end
        assertions++;
        if (n_wr_en != 1 || wr_data !== exp || wr_idx !== 6'd63 || wr_way !== 2'd3) begin
            failures++;
            $display("FAIL wb_fill_write: got n=%0d idx=%0d way=%0d low=%h want 1/63/3 low=%h",
                     n_wr_en, wr_idx, wr_way, wr_data[63:0], exp[63:0]);
        end
    endtask

    task automatic test_stalls();
        logic [511:0] exp;
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 16; w++) da_line_read_data[32*w +: 32] = $urandom;
            for (int i = 0; i < 8; i++) begin
                rbeats[i] = {$urandom, $urandom};
                exp[64*i +: 64] = rbeats[i];
            end
            run_txn(1'b1, 6'(r + 10), 2'(r), 32'h8000_0000 + 32'(r * 64), 32'h4000_0000 + 32'(r * 64), 45, 7, -1, 1'b0);
            assertions++;
            if (!got_done || n_cmd != 2 || n_wbeat != 8 || n_rbeat != 8 || stab_viol != 0) begin
                failures++;
                $display("FAIL stall_counts%0d: got done=%0b cmds=%0d wbeats=%0d rbeats=%0d unstable=%0d want 1/2/8/8/0",
                         r, got_done, n_cmd, n_wbeat, n_rbeat, stab_viol);
            end
            for (int i = 0; i < 8; i++) begin
                assertions++;
                if (wbeat_l[i] !== da_line_read_data[64*i +: 64] || wlast_l[i] !== (i == 7)) begin
                    failures++;
                    $display("FAIL stall_wbeat%0d_%0d: got %h want %h", r, i, wbeat_l[i], da_line_read_data[64*i +: 64]);
                end
            end
            assertions++;
            if (n_wr_en != 1 || wr_data !== exp || done_err !== 1'b0) begin
                failures++;
                $display("FAIL stall_fill%0d: got writes=%0d err=%b low=%h want 1/0 low=%h",
                         r, n_wr_en, done_err, wr_data[63:0], exp[63:0]);
            end
        end
    endtask

    task automatic test_rdata_last_err();
        logic [511:0] exp;
        for (int i = 0; i < 8; i++) begin
            rbeats[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
            exp[64*i +: 64] = 64'hC0DE_0000_0000_0000 + 64'(i);
        end
        run_txn(1'b0, 6'd7, 2'd1, 32'h0, 32'h0000_2000, 0, 3, -1, 1'b0);
        assertions++;
        if (!got_done || done_err !== 1'b1 || n_rbeat != 8) begin
            failures++;
            $display("FAIL early_last: got done=%0b err=%b beats=%0d want 1/1/8", got_done, done_err, n_rbeat);
        end
        assertions++;
        if (n_wr_en != 1 || wr_data !== exp) begin
            failures++;
            $display("FAIL early_last_data: got writes=%0d low=%h want 1 low=%h", n_wr_en, wr_data[63:0], exp[63:0]);
        end
        run_txn(1'b0, 6'd7, 2'd1, 32'h0, 32'h0000_2040, 0, 7, -1, 1'b0);
        assertions++;
        if (!got_done || done_err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared: got done=%0b err=%b want 1/0", got_done, done_err);
        end
        run_txn(1'b0, 6'd7, 2'd1, 32'h0, 32'h0000_2080, 0, -1, -1, 1'b0);
        assertions++;
        if (!got_done || done_err !== 1'b1 || n_rbeat != 8) begin
            failures++;
            $display("FAIL missing_last: got done=%0b err=%b beats=%0d want 1/1/8", got_done, done_err, n_rbeat);
        end
    endtask

    task automatic test_reset_mid_fill();
        int we_before;
        for (int i = 0; i < 8; i++) rbeats[i] = 64'hDEAD_BEEF_0000_0000 + 64'(i);
        we_before = we_total;
        run_txn(1'b0, 6'd20, 2'd0, 32'h0, 32'h0000_3000, 0, 7, 5, 1'b0);
        assertions++;
        if (!aborted || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got aborted=%0b req_ready=%b busy=%b want 1/1/0", aborted, req_ready, busy);
        end
        repeat (4) @(negedge clk);
        assertions++;
        if (we_total != we_before || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_write: got write_en pulses=%0d done=%b want 0/0", we_total - we_before, done);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) rbeats[i] = 64'h0F0F_0000_0000_0000 + 64'(i);
        run_txn(1'b1, 6'd33, 2'd2, 32'h0000_5000, 32'h0000_6000, 0, 7, -1, 1'b1);
        assertions++;
        if (!got_done || accepts != 1 || n_wr_en != 1 || n_cmd != 2) begin
            failures++;
            $display("FAIL held_req: got done=%0b accepts=%0d writes=%0d cmds=%0d want 1/1/1/2",
                     got_done, accepts, n_wr_en, n_cmd);
        end
        @(negedge clk);
        assertions++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done_idle: got req_ready=%b busy=%b want 1/0", req_ready, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_writeback = 1'b0; req_index = '0; req_way = '0;
        req_wb_addr = '0; req_fill_addr = '0; da_line_read_data = '0;
        mem_cmd_ready = 1'b0; mem_wdata_ready = 1'b0;
        mem_rdata_valid = 1'b0; mem_rdata = '0; mem_rdata_last = 1'b0;
        test_reset();
        test_fill_only();
        test_writeback_fill();
        test_stalls();
        test_rdata_last_err();
        test_reset_mid_fill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
